// File: rtl/ahb_line_fill_master.sv
// AHB-Lite line-fill master: one fixed-length read burst per I-cache miss.
// Build option CRITICAL_WORD_FIRST_EN: wrapping burst that starts at the missed word.
`timescale 1ns/1ps
module ahb_line_fill_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 4,
  localparam int IDX_W     = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  output logic                  fill_valid,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic [IDX_W-1:0]      fill_idx,
  output logic                  fill_done
);
  // state | meaning
  // IDLE  | waiting for a miss request
  // ADDR  | NONSEQ address phase of the first beat
  // BURST | overlapped SEQ address / data phases until the last beat returns
  typedef enum logic [1:0] {IDLE, ADDR, BURST} state_t;

  localparam int               CNT_W      = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_END    = CNT_W'(BEATS);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BEATS - 1);
  localparam logic [1:0]       TR_IDLE    = 2'b00;
  localparam logic [1:0]       TR_NONSEQ  = 2'b10;
  localparam logic [1:0]       TR_SEQ     = 2'b11;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [2:0] BURST_CODE = (BEATS == 16) ? 3'b110 : (BEATS == 8) ? 3'b100 : 3'b010;
`else
  localparam logic [2:0] BURST_CODE = (BEATS == 16) ? 3'b111 : (BEATS == 8) ? 3'b101 : 3'b011;
`endif

  state_t                      state, state_nxt;
  logic [ADDR_WIDTH-1:IDX_W+2] line_base;
  logic [IDX_W-1:0]            start_idx;
  logic [IDX_W-1:0]            beat_idx;
  logic [CNT_W-1:0]            addr_cnt;
  logic [IDX_W-1:0]            data_cnt;
  logic                        accept;
  logic                        capture;
  logic                        unused_addr_bits;

  // Holding off req_ready during the fill_done cycle keeps the following cycle IDLE.
  assign req_ready = (state == IDLE) && !fill_done;
  assign accept    = req_valid && req_ready;
  assign capture   = (state == BURST) && hready;
  assign hwrite    = 1'b0;
  assign hsize     = 3'b010;

`ifdef CRITICAL_WORD_FIRST_EN
  assign unused_addr_bits = ^req_addr[1:0];
`else
  assign unused_addr_bits = ^req_addr[IDX_W+1:0];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    htrans    = TR_IDLE;
    hburst    = 3'b000;
    haddr     = '0;
    beat_idx  = start_idx + ((state == BURST) ? addr_cnt[IDX_W-1:0] : '0);
    case (state)
      IDLE: begin
        if (req_valid && !fill_done) state_nxt = ADDR;
      end
      ADDR: begin
        htrans = TR_NONSEQ;
        hburst = BURST_CODE;
        haddr  = {line_base, beat_idx, 2'b00};
        if (hready) state_nxt = BURST;
      end
      BURST: begin
        hburst = BURST_CODE;
        haddr  = {line_base, beat_idx, 2'b00};
        if (addr_cnt < CNT_END) htrans = TR_SEQ;
        if (hready && (data_cnt == IDX_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_base  <= '0;
      start_idx  <= '0;
      addr_cnt   <= '0;
      data_cnt   <= '0;
      fill_valid <= 1'b0;
      fill_data  <= '0;
      fill_idx   <= '0;
      fill_done  <= 1'b0;
    end else begin
      fill_valid <= capture;
      fill_done  <= capture && (data_cnt == IDX_LAST);
      if (accept) begin
        line_base <= req_addr[ADDR_WIDTH-1:IDX_W+2];
`ifdef CRITICAL_WORD_FIRST_EN
        start_idx <= req_addr[IDX_W+1:2];
`else
        start_idx <= '0;
`endif
        addr_cnt  <= '0;
        data_cnt  <= '0;
      end
      if ((state == ADDR) && hready) addr_cnt <= CNT_W'(1);
      if (capture) begin
        fill_data <= hrdata;
        fill_idx  <= start_idx + data_cnt;
        data_cnt  <= data_cnt + IDX_W'(1);
        if (addr_cnt < CNT_END) addr_cnt <= addr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahb_line_fill_master.sv
// Scoreboard bench for ahb_line_fill_master (BEATS=4); expectations follow CRITICAL_WORD_FIRST_EN.
`timescale 1ns/1ps
module tb_ahb_line_fill_master;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hrdata;
  logic        hready;
  logic        fill_valid;
  logic [31:0] fill_data;
  logic [1:0]  fill_idx;
  logic        fill_done;

  ahb_line_fill_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BEATS(4)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hrdata(hrdata), .hready(hready), .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_idx(fill_idx), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [2:0]  EXP_HBURST = 3'b010;
  localparam logic [31:0] EXP_STALL_ADDR = 32'h0000_123C;
`else
  localparam logic [2:0]  EXP_HBURST = 3'b011;
  localparam logic [31:0] EXP_STALL_ADDR = 32'h0000_1234;
`endif

  typedef struct packed { logic [31:0] addr; logic [1:0] trans; } aph_t;
  typedef struct packed { logic [1:0] idx; logic [31:0] data; logic done; } beat_t;

  aph_t  aq[$];
  beat_t bq[$];
  int    lq[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, acc_cyc = 0, last_done_cyc = -100;
  int n_acc = 0, beats_seen = 0, dones_seen = 0;
  logic [31:0] dp_addr = 32'h0;

  // Subordinate model: data returned for a beat is a fixed function of its address.
  assign hrdata = dp_addr ^ 32'hC0DE_0000;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (hready && htrans[1]) dp_addr <= haddr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push_line(input logic [31:0] a0, a1, a2, a3,
                           input logic [1:0] i0, i1, i2, i3, input int lat);
    logic [31:0] a [4];
    logic [1:0]  ix [4];
    a  = '{a0, a1, a2, a3};
    ix = '{i0, i1, i2, i3};
    for (int k = 0; k < 4; k++) begin
      aq.push_back('{addr: a[k], trans: (k == 0) ? 2'b10 : 2'b11});
      bq.push_back('{idx: ix[k], data: a[k] ^ 32'hC0DE_0000, done: (k == 3)});
    end
    lq.push_back(lat);
  endtask

  task automatic push_1238(input int lat);
`ifdef CRITICAL_WORD_FIRST_EN
    push_line(32'h1238, 32'h123C, 32'h1230, 32'h1234, 2'd2, 2'd3, 2'd0, 2'd1, lat);
`else
    push_line(32'h1230, 32'h1234, 32'h1238, 32'h123C, 2'd0, 2'd1, 2'd2, 2'd3, lat);
`endif
  endtask

  task automatic push_4ff4(input int lat);
`ifdef CRITICAL_WORD_FIRST_EN
    push_line(32'h4FF4, 32'h4FF8, 32'h4FFC, 32'h4FF0, 2'd1, 2'd2, 2'd3, 2'd0, lat);
`else
    push_line(32'h4FF0, 32'h4FF4, 32'h4FF8, 32'h4FFC, 2'd0, 2'd1, 2'd2, 2'd3, lat);
`endif
  endtask

  // Monitor: pops expected address phases and beats as the DUT presents them.
  always @(negedge clk) begin
    if (rstn) begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        n_acc++;
      end
      if (htrans != 2'b00) chk("req_ready_busy", req_ready, 32'd0);
      if (htrans[1] && hready) begin
        if (aq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_aphase: got haddr %h, expected no transfer", haddr);
        end else begin
          aph_t e;
          e = aq.pop_front();
          chk("haddr", haddr, e.addr);
          chk("htrans", htrans, e.trans);
          chk("hburst", hburst, EXP_HBURST);
          chk("hwrite", hwrite, 32'd0);
          chk("hsize", hsize, 32'd2);
          if (htrans == 2'b10) chk("nonseq_gap_ok", (cyc - last_done_cyc >= 2), 32'd1);
        end
      end
      if (fill_valid) begin
        beats_seen++;
        chk("req_ready_fill", req_ready, 32'd0);
        if (bq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_fill: got idx %0d, expected no beat", fill_idx);
        end else begin
          beat_t b;
          b = bq.pop_front();
          chk("fill_idx", fill_idx, b.idx);
          chk("fill_data", fill_data, b.data);
          chk("fill_done", fill_done, b.done);
        end
      end else if (fill_done) begin
        n_chk++;
        $display("FAIL done_without_valid: got fill_done 1, expected 0");
      end
      if (fill_done) begin
        dones_seen++;
        last_done_cyc = cyc;
        if (lq.size() != 0) chk("latency", cyc - acc_cyc, lq.pop_front());
      end
    end
  end

  task automatic wait_acc(input int target);
    int k = 0;
    while (n_acc < target && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_acc < target) begin
      n_chk++;
      $display("FAIL accept_timeout: got %0d accepts, expected %0d", n_acc, target);
    end
    @(posedge clk); #1;
  endtask

  task automatic start_req(input logic [31:0] a);
    int t;
    @(posedge clk); #1;
    t = n_acc;
    req_addr  = a;
    req_valid = 1'b1;
    wait_acc(t + 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (dones_seen < target && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    if (dones_seen < target) begin
      n_chk++;
      $display("FAIL done_timeout: got %0d completions, expected %0d", dones_seen, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_acc, k;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    hready    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 32'd1);
    chk("rst_htrans", htrans, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hburst", hburst, 32'd0);
    chk("rst_fill_valid", fill_valid, 32'd0);
    chk("rst_fill_done", fill_done, 32'd0);
    chk("rst_fill_idx", fill_idx, 32'd0);
    chk("rst_fill_data", fill_data, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_req_ready", req_ready, 32'd1);
    chk("idle_htrans", htrans, 32'd0);
    chk("idle_fill_valid", fill_valid, 32'd0);
    chk("idle_fill_done", fill_done, 32'd0);

    // zero wait states
    push_1238(6);
    start_req(32'h0000_1238);
    wait_done(1);

    // three-cycle stall during the beat-1 address phase
    push_1238(9);
    start_req(32'h0000_1238);
    @(posedge clk); #1;
    hready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_haddr", haddr, EXP_STALL_ADDR);
      chk("stall_htrans", htrans, 32'd3);
      chk("stall_fill_valid", fill_valid, 32'd0);
    end
    @(posedge clk); #1;
    hready = 1'b1;
    wait_done(2);

    // a different word within the line
    push_4ff4(6);
    start_req(32'h0000_4FF4);
    wait_done(3);

    // reset after two beats have been returned
    push_1238(6);
    base = beats_seen;
    start_req(32'h0000_1238);
    k = 0;
    while (beats_seen < base + 2 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    if (beats_seen < base + 2) begin
      n_chk++;
      $display("FAIL midburst_timeout: got %0d beats, expected %0d", beats_seen - base, 2);
    end
    rstn = 1'b0;
    #1;
    chk("mid_rst_htrans", htrans, 32'd0);
    chk("mid_rst_req_ready", req_ready, 32'd1);
    chk("mid_rst_fill_valid", fill_valid, 32'd0);
    chk("mid_rst_fill_done", fill_done, 32'd0);
    aq.delete();
    bq.delete();
    lq.delete();
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_fill_valid", fill_valid, 32'd0);
      chk("in_rst_htrans", htrans, 32'd0);
    end
    #2;
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_fill_valid", fill_valid, 32'd0);
      chk("post_rst_fill_done", fill_done, 32'd0);
    end
    push_line(32'h2000, 32'h2004, 32'h2008, 32'h200C, 2'd0, 2'd1, 2'd2, 2'd3, 6);
    start_req(32'h0000_2000);
    wait_done(4);

    // request held high across completion: two bursts, gap checked by the monitor
    push_1238(6);
    push_1238(6);
    @(posedge clk); #1;
    base_acc  = n_acc;
    req_addr  = 32'h0000_1238;
    req_valid = 1'b1;
    wait_acc(base_acc + 2);
    req_valid = 1'b0;
    wait_done(6);

    repeat (3) @(negedge clk);
    chk("aq_empty", aq.size(), 32'd0);
    chk("bq_empty", bq.size(), 32'd0);
    chk("lq_empty", lq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
